tmds_decoder: RTL and testbench

- Receive-side counterpart of the TMDS encoder. Takes one serial TMDS lane at bit rate, one bit per `clk`, least-significant bit first.
- Finds the 10-bit word boundary by hunting for repeated control tokens, then decodes each aligned word into pixel data or control bits.
- Sits between the lane input and the sink pixel pipeline, which consumes `word_valid` strobes (one per 10 clocks).

---
 rtl/tmds_decoder_if.sv | 36 +++
 rtl/tmds_decoder.sv | 174 +++++++++++++++++
 tb/tb_tmds_decoder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/tmds_decoder_if.sv
// -----------------------------------------------------------------------------
// tmds_decoder_if
//   Bundles the serial TMDS lane input and the decoded word outputs of
//   tmds_decoder.
//   master : lane source / pixel sink side (drives ser_in, observes words)
//   slave  : the decoder itself (consumes ser_in, drives word outputs)
// Signals:
//   ser_in      serial TMDS bit, LSB of each 10-bit word first
//   word_valid  one-cycle strobe, word fields valid this cycle
//   raw_word    aligned 10-bit symbol as received
//   pixel_data  decoded byte (meaningful when de=1)
//   de          1 = data word, 0 = control token
//   ctrl        {C1,C0} of a control token (meaningful when de=0)
//   locked      word alignment acquired
//   guard       video guard-band symbol flag
// -----------------------------------------------------------------------------
interface tmds_decoder_if;
    logic       ser_in;
    logic       word_valid;
    logic [9:0] raw_word;
    logic [7:0] pixel_data;
    logic       de;
    logic [1:0] ctrl;
    logic       locked;
    logic       guard;

    modport master (
        output ser_in,
        input  word_valid, raw_word, pixel_data, de, ctrl, locked, guard
    );

    modport slave (
        input  ser_in,
        output word_valid, raw_word, pixel_data, de, ctrl, locked, guard
    );
endinterface

// File: rtl/tmds_decoder.sv
// -----------------------------------------------------------------------------
// tmds_decoder
//   Single-lane TMDS receiver back end. Deserialises the bit stream, hunts for
//   CTRL_RUN consecutive control tokens at one bit phase to find the word
//   boundary, then decodes every aligned word into pixel data or control bits.
//   Lock is dropped after MAX_GAP aligned words without a control token.
// Ports:
//   clk    bit-rate clock
//   n_rst  asynchronous active-low reset
//   bus    tmds_decoder_if.slave (ser_in in; word strobe/fields, locked out)
// Build option:
//   TMDS_GUARD_DETECT_EN  when defined, flag guard-band symbols 0x2CC/0x133
//                         on the guard output; otherwise guard is tied to 0.
// -----------------------------------------------------------------------------
module tmds_decoder #(
    parameter  int CTRL_RUN = 8,
    parameter  int MAX_GAP  = 4096,
    localparam int GAP_W    = $clog2(MAX_GAP + 1)
) (
    input  logic           clk,
    input  logic           n_rst,
    tmds_decoder_if.slave  bus
);
    localparam int RUN_W = $clog2(CTRL_RUN + 1);

    typedef enum logic {S_HUNT, S_LOCKED} state_t;

    state_t           r_state, w_state_nxt;
    logic [9:0]       r_sr;
    logic [3:0]       r_ph, r_lock_ph, w_lock_ph_nxt;
    logic [RUN_W-1:0] r_run, w_run_nxt;
    logic [GAP_W-1:0] r_gap, w_gap_nxt;

    logic       r_wv;
    logic [9:0] r_raw;
    logic [7:0] r_pix;
    logic       r_de;
    logic [1:0] r_ctrl;
    logic       r_guard;

    logic       w_tok;
    logic [1:0] w_tctrl;
    logic [9:0] w_q;
    logic [7:0] w_dec;
    logic       w_guard;
    logic       w_at_ph;
    logic       w_emit;

    assign w_at_ph = (r_ph == r_lock_ph);

    // Control token match on the current 10-bit window.
    always_comb begin
        w_tok   = 1'b1;
        w_tctrl = 2'b00;
        case (r_sr)
            10'h354: w_tctrl = 2'b00;
            10'h0AB: w_tctrl = 2'b01;
            10'h154: w_tctrl = 2'b10;
            10'h2AB: w_tctrl = 2'b11;
            default: w_tok = 1'b0;
        endcase
    end

    // Data decode: undo the optional inversion, then the XOR/XNOR chain
    // selected by bit 8.
    always_comb begin
        w_q = r_sr;
        if (r_sr[9]) w_q[7:0] = ~r_sr[7:0];
        w_dec    = '0;
        w_dec[0] = w_q[0];
        for (int i = 1; i < 8; i++)
            w_dec[i] = w_q[8] ? (w_q[i] ^ w_q[i-1]) : ~(w_q[i] ^ w_q[i-1]);
    end

`ifdef TMDS_GUARD_DETECT_EN
    assign w_guard = (r_sr == 10'h2CC) || (r_sr == 10'h133);
`else
    assign w_guard = 1'b0;
`endif

    // Next-state / counter logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_run_nxt     = r_run;
        w_lock_ph_nxt = r_lock_ph;
        w_gap_nxt     = r_gap;
        w_emit        = 1'b0;
        case (r_state)
            S_HUNT: begin
                if (w_tok) begin
                    // A token at a new phase restarts the run there.
                    if (r_run == '0 || !w_at_ph) begin
                        w_lock_ph_nxt = r_ph;
                        w_run_nxt     = RUN_W'(1);
                    end else begin
                        w_run_nxt = r_run + 1'b1;
                    end
                    if (w_run_nxt == RUN_W'(CTRL_RUN)) begin
                        w_state_nxt = S_LOCKED;
                        w_gap_nxt   = '0;
                    end
                end else if (w_at_ph && r_run != '0) begin
                    w_run_nxt = '0;
                end
            end
            S_LOCKED: begin
                if (w_at_ph) begin
                    w_emit = 1'b1;
                    if (w_tok) begin
                        w_gap_nxt = '0;
                    end else if (r_gap == GAP_W'(MAX_GAP - 1)) begin
                        // This word is still emitted; alignment is re-hunted after it.
                        w_state_nxt = S_HUNT;
                        w_run_nxt   = '0;
                    end else begin
                        w_gap_nxt = r_gap + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= S_HUNT;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sr      <= '0;
            r_ph      <= '0;
            r_lock_ph <= '0;
            r_run     <= '0;
            r_gap     <= '0;
        end else begin
            r_sr      <= {bus.ser_in, r_sr[9:1]};
            r_ph      <= (r_ph == 4'd9) ? 4'd0 : r_ph + 4'd1;
            r_lock_ph <= w_lock_ph_nxt;
            r_run     <= w_run_nxt;
            r_gap     <= w_gap_nxt;
        end
    end

    // Word outputs hold between strobes; only word_valid pulses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wv    <= 1'b0;
            r_raw   <= '0;
            r_pix   <= '0;
            r_de    <= 1'b0;
            r_ctrl  <= '0;
            r_guard <= 1'b0;
        end else begin
            r_wv <= w_emit;
            if (w_emit) begin
                r_raw   <= r_sr;
                r_de    <= ~w_tok;
                r_pix   <= w_tok ? 8'h00 : w_dec;
                r_ctrl  <= w_tok ? w_tctrl : 2'b00;
                r_guard <= w_guard;
            end
        end
    end

    assign bus.word_valid = r_wv;
    assign bus.raw_word   = r_raw;
    assign bus.pixel_data = r_pix;
    assign bus.de         = r_de;
    assign bus.ctrl       = r_ctrl;
    assign bus.guard      = r_guard;
    assign bus.locked     = (r_state == S_LOCKED);

endmodule

// File: tb/tb_tmds_decoder.sv
// -----------------------------------------------------------------------------
// tb_tmds_decoder
//   Drives LSB-first TMDS words into tmds_decoder (MAX_GAP=16) and compares
//   every word strobe against a scoreboard of expected words, including the
//   exact strobe cycle. Lock rise/fall cycles are tracked and checked too.
// -----------------------------------------------------------------------------
module tb_tmds_decoder;
    localparam int MAX_GAP = 16;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    tmds_decoder_if bus();

    tmds_decoder #(.CTRL_RUN(8), .MAX_GAP(MAX_GAP)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    typedef struct {
        logic [9:0] raw;
        logic [7:0] pix;
        logic       de;
        logic [1:0] ctrl;
        logic       g;
        int         edg;
    } exp_t;

    exp_t sb[$];

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int last_edge = 0;
    int rise_edge = -1;
    int fall_edge = -1;
    int tok_edge;
    int drop_edge;
    logic prev_lk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [9:0] w, input int edg);
        exp_t e;
        logic [9:0] q;
        e.raw = w; e.edg = edg; e.pix = 8'h00; e.de = 1'b0; e.ctrl = 2'b00; e.g = 1'b0;
        case (w)
            10'h354: e.ctrl = 2'b00;
            10'h0AB: e.ctrl = 2'b01;
            10'h154: e.ctrl = 2'b10;
            10'h2AB: e.ctrl = 2'b11;
            default: begin
                e.de = 1'b1;
                q = w;
                if (q[9]) q[7:0] = ~q[7:0];
                e.pix[0] = q[0];
                for (int i = 1; i < 8; i++) e.pix[i] = q[i] ^ q[i-1] ^ ~q[8];
`ifdef TMDS_GUARD_DETECT_EN
                e.g = (w == 10'h2CC) || (w == 10'h133);
`endif
            end
        endcase
        return e;
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.ser_in = b;
        last_edge  = cyc + 1;   // posedge that samples this bit
    endtask

    task automatic send_word(input logic [9:0] w, input bit push);
        for (int i = 0; i < 10; i++) send_bit(w[i]);
        if (push) sb.push_back(model(w, last_edge + 1));
    endtask

    // Strobe monitor / scoreboard consumer, plus lock edge tracking.
    always @(negedge clk) begin : mon
        exp_t e;
        if (n_rst) begin
            if (bus.word_valid) begin
                if (sb.size() == 0) begin
                    chk("spur_wv", 32'(bus.word_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("raw",   32'(bus.raw_word),   32'(e.raw));
                    chk("pix",   32'(bus.pixel_data), 32'(e.pix));
                    chk("de",    32'(bus.de),         32'(e.de));
                    chk("ctrl",  32'(bus.ctrl),       32'(e.ctrl));
                    chk("guard", 32'(bus.guard),      32'(e.g));
                    chk("lat",   cyc,                 e.edg);
                end
            end
            if (bus.locked && !prev_lk) rise_edge = cyc;
            if (!bus.locked && prev_lk) fall_edge = cyc;
            prev_lk = bus.locked;
        end else begin
            prev_lk = 1'b0;
        end
    end

    initial begin
        bus.ser_in = 1'b0;
        n_rst      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out", 32'({bus.word_valid, bus.raw_word, bus.pixel_data, bus.de,
                            bus.ctrl, bus.locked, bus.guard}), 32'd0);
        n_rst = 1'b1;

        // Junk bits, then a run of 0x354 tokens to acquire lock.
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (8) send_word(10'h354, 1'b0);
        tok_edge = last_edge;
        chk("pre_lock2", 32'(bus.locked), 32'd0);
        send_word(10'h154, 1'b1);
        chk("lock_t2", rise_edge, tok_edge + 1);

        // Guard-band style data words, both decode to 0x55.
        send_word(10'h133, 1'b1);
        send_word(10'h3CC, 1'b1);

        // 0x294 then 0x35A puts a 0x354 window 5 bits off the word phase.
        send_word(10'h294, 1'b1);
        send_word(10'h35A, 1'b1);
        send_word(10'h133, 1'b1);
        chk("lock_t6", 32'(bus.locked), 32'd1);
        chk("nofall6", fall_edge, -1);

        // Gap timeout: token clears gap, then MAX_GAP data words drop lock.
        send_word(10'h354, 1'b1);
        repeat (MAX_GAP) send_word(10'h133, 1'b1);
        drop_edge = last_edge + 1;
        repeat (8) send_word(10'h2AB, 1'b0);
        tok_edge = last_edge;
        chk("drop_t5", fall_edge, drop_edge);
        chk("pre_lock5", 32'(bus.locked), 32'd0);
        send_word(10'h2AB, 1'b1);
        chk("relock_t5", rise_edge, tok_edge + 1);

        // Reset in the middle of a word.
        send_word(10'h133, 1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        #2 n_rst = 1'b0;
        @(negedge clk);
        chk("rst_mid", 32'({bus.word_valid, bus.raw_word, bus.pixel_data, bus.de,
                            bus.ctrl, bus.locked, bus.guard}), 32'd0);
        repeat (2) @(negedge clk);
        rise_edge = -1;
        fall_edge = -1;
        n_rst = 1'b1;

        // Phase shift during hunt restarts the run.
        repeat (5) send_word(10'h0AB, 1'b0);
        send_bit(1'b1);
        repeat (7) send_word(10'h0AB, 1'b0);
        chk("nolock4", 32'(bus.locked), 32'd0);
        chk("norise4", rise_edge, -1);
        send_word(10'h0AB, 1'b0);
        tok_edge = last_edge;
        send_word(10'h0AB, 1'b1);
        chk("lock_t4", rise_edge, tok_edge + 1);

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
